// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serializer.
// The PARITY state only exists when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam bit DEF_LSB_FIRST = 1'b1;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/piso_bitcnt.sv
// Loadable bit counter; tc_o flags the last bit position (WIDTH-1) of a frame.
module piso_bitcnt #(
    parameter int  WIDTH = 4,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic clear,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with back-to-back word acceptance.
// Optional trailing even-parity bit is enabled by defining PISO_PARITY_EN.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = DEF_LSB_FIRST
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] pi_data,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic               so_q, so_d;
    logic               soValid_q, soValid_d;
    logic               cntTc;
    logic               xfer;
`ifdef PISO_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign xfer = pi_valid && pi_ready;

    piso_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk    (clk),
        .clear  (clear),
        .load_i (xfer),
        .en_i   (state_q == SHIFT),
        .tc_o   (cntTc)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (xfer) state_d = SHIFT;
            SHIFT: begin
                if (cntTc) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = xfer ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_d = xfer ? SHIFT : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // The frame's closing cycle both accepts the next word and marks completion.
    always_comb begin
        pi_ready   = 1'b0;
        frame_done = 1'b0;
        if (!clear) begin
            unique case (state_q)
                IDLE: pi_ready = 1'b1;
`ifdef PISO_PARITY_EN
                SHIFT: begin
                    pi_ready   = 1'b0;
                    frame_done = 1'b0;
                end
                PARITY: begin
                    pi_ready   = 1'b1;
                    frame_done = 1'b1;
                end
`else
                SHIFT: begin
                    pi_ready   = cntTc;
                    frame_done = cntTc;
                end
`endif
                default: pi_ready = 1'b0;
            endcase
        end
    end

    // First bit is emitted straight from pi_data so it appears one cycle after the transfer.
    always_comb begin
        so_d       = 1'b0;
        soValid_d  = 1'b0;
        shiftReg_d = shiftReg_q;
`ifdef PISO_PARITY_EN
        parity_d   = parity_q;
`endif
        if (xfer) begin
            soValid_d = 1'b1;
            if (LSB_FIRST) begin
                so_d       = pi_data[0];
                shiftReg_d = {1'b0, pi_data[WIDTH-1:1]};
            end else begin
                so_d       = pi_data[WIDTH-1];
                shiftReg_d = {pi_data[WIDTH-2:0], 1'b0};
            end
`ifdef PISO_PARITY_EN
            parity_d = ^pi_data;
`endif
        end else if (state_q == SHIFT && !cntTc) begin
            soValid_d = 1'b1;
            if (LSB_FIRST) begin
                so_d       = shiftReg_q[0];
                shiftReg_d = shiftReg_q >> 1;
            end else begin
                so_d       = shiftReg_q[WIDTH-1];
                shiftReg_d = shiftReg_q << 1;
            end
`ifdef PISO_PARITY_EN
        end else if (state_q == SHIFT) begin
            so_d      = parity_q;
            soValid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            shiftReg_q <= '0;
            so_q       <= 1'b0;
            soValid_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            shiftReg_q <= shiftReg_d;
            so_q       <= so_d;
            soValid_q  <= soValid_d;
`ifdef PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign so       = so_q;
    assign so_valid = soValid_q;

endmodule
